// File: rtl/seg_scan_if.sv
// seg_scan_if: strobe inputs, digit data and display pin bundle for seg_scan_driver.
interface seg_scan_if #(
    parameter int NDIG = 6,
    parameter int IDXW = 3
);
    logic              clk_300hz;
    logic              clk_4hz;
    logic [4*NDIG-1:0] bcd_in;
    logic [NDIG-1:0]   blink_mask;
    logic [NDIG-1:0]   dp_mask;
    logic [7:0]        seg_out;
    logic [NDIG-1:0]   dig_sel;
    logic [IDXW-1:0]   scan_idx;

    modport master (
        output clk_300hz, clk_4hz, bcd_in, blink_mask, dp_mask,
        input  seg_out, dig_sel, scan_idx
    );

    modport slave (
        input  clk_300hz, clk_4hz, bcd_in, blink_mask, dp_mask,
        output seg_out, dig_sel, scan_idx
    );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: scans NDIG BCD digits onto a common-segment display with one blank cycle between digits and per-digit blink.
module seg_scan_driver #(
    parameter int NDIG = 6,
    parameter int IDXW = 3
) (
    input logic       clk,
    input logic       rst_n,
    seg_scan_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t          state, state_nxt;
    logic [1:0]      s300, s4;
    logic            scan_edge, blink_phase;
    logic [IDXW-1:0] next_idx, idx_q, idx_nxt;
    logic [NDIG-1:0] sel_q;
    logic [7:0]      seg_q;
    logic            blink_q;
    logic [3:0]      code;

    function automatic logic [6:0] dec(input logic [3:0] c);
        case (c)
            4'd0: dec = 7'h3F;
            4'd1: dec = 7'h06;
            4'd2: dec = 7'h5B;
            4'd3: dec = 7'h4F;
            4'd4: dec = 7'h66;
            4'd5: dec = 7'h6D;
            4'd6: dec = 7'h7D;
            4'd7: dec = 7'h07;
            4'd8: dec = 7'h7F;
            4'd9: dec = 7'h6F;
            default: dec = 7'h00;
        endcase
    endfunction

    assign scan_edge   = s300[0] & ~s300[1];
    assign blink_phase = s4[1];
    assign code        = 4'(bus.bcd_in >> {next_idx, 2'b00});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    // Edges arriving during BLANK are dropped rather than queued.
    always_comb begin
        state_nxt = state == BLANK ? DRIVE : scan_edge ? BLANK : state;
        idx_nxt   = (state == IDLE || idx_q == IDXW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s300     <= '0;
            s4       <= '0;
            next_idx <= '0;
            idx_q    <= '0;
            sel_q    <= '1;
            seg_q    <= '0;
            blink_q  <= 1'b0;
        end else begin
            s300 <= {s300[0], bus.clk_300hz};
            s4   <= {s4[0], bus.clk_4hz};
            if (state_nxt == BLANK) begin
                next_idx <= idx_nxt;
                sel_q    <= '1;
                seg_q    <= '0;
                blink_q  <= 1'b0;
            end else if (state == BLANK) begin
                idx_q   <= next_idx;
                sel_q   <= ~(NDIG'(1) << next_idx);
                seg_q   <= {bus.dp_mask[next_idx], dec(code)};
                blink_q <= bus.blink_mask[next_idx];
            end
        end
    end

    // Blink gating uses the live phase so the blink tracks clk_4hz during DRIVE.
    assign bus.seg_out  = (blink_q & blink_phase) ? 8'h00 : seg_q;
    assign bus.dig_sel  = sel_q;
    assign bus.scan_idx = idx_q;
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Consumes the divided strobes produced by the clock divider: the scan square wave (nominally 300 Hz) and the blink square wave (nominally 4 Hz).
- Time-multiplexes NDIG BCD digits onto a common-segment 7-segment display.
- Adds one blanking cycle between digits to suppress ghosting.
- Blanks selected digits at the blink rate so the user can see which time field is being set.
- Sits between the timekeeping/set logic and the display pins, in the same single clock domain as the divider.

Parameters:
- NDIG, 6, number of display digits; legal range 2..8.
- IDXW, 3, width of the digit index; must satisfy 2^IDXW >= NDIG.

Ports:
- clk  input  1  system clock; same clock that drives the divider.
- rst_n  input  1  asynchronous active-low reset.
- clk_300hz  input  1  scan square wave from the divider; each rising edge advances the scan.
- clk_4hz  input  1  blink square wave from the divider; its level selects the blink phase.
- bcd_in  input  4*NDIG  packed BCD; digit k is bcd_in[4k+3:4k]; digit 0 is rightmost.
- blink_mask  input  NDIG  bit k=1: digit k blinks.
- dp_mask  input  NDIG  bit k=1: decimal point of digit k is lit.
- seg_out  output  8  segments, active-high; bit0=a … bit6=g, bit7=dp.
- dig_sel  output  NDIG  digit enables, one-hot active-low; all-ones means no digit is driven.
- scan_idx  output  IDXW  index of the digit currently driven; for debug and verification.

Behaviour:
- Reset (async, rst_n=0):
  - seg_out=8'h00, dig_sel=all ones, scan_idx=0.
  - FSM=IDLE; synchronizer flops = 0; blink_phase = 0.
  - Reset asserted mid-scan forces these values immediately, without waiting for a clock edge.
- Input sampling:
  - clk_300hz and clk_4hz each pass through two flops, s0 then s1.
  - scan_edge = s0 & ~s1 of clk_300hz.
  - blink_phase = s1 of clk_4hz.
- FSM states: IDLE, BLANK, DRIVE.
  - IDLE: outputs stay at reset values. scan_edge moves to BLANK with next_idx=0.
  - BLANK (exactly 1 cycle): dig_sel=all ones, seg_out=0. Latch bcd_in, blink_mask and dp_mask for digit next_idx. Then go to DRIVE with scan_idx=next_idx.
  - DRIVE: hold outputs for the latched digit. scan_edge moves to BLANK with next_idx = scan_idx+1; when scan_idx=NDIG-1 the index wraps to 0.
  - A scan_edge arriving while in BLANK is ignored, not queued.
- Latency: if clk_300hz rises before clk edge E0, then:
  - s0=1 at E0 and scan_edge is high during cycle E0.
  - BLANK outputs appear at E1.
  - New-digit outputs appear at E2.
- Output values in DRIVE for digit k:
  - dig_sel[k]=0; all other bits of dig_sel = 1.
  - seg_out[6:0] comes from the latched BCD. Codes 0..9 map to 3F,06,5B,4F,66,6D,7D,07,7F,6F. Codes 10..15 map to 00 (blank, used for leading-zero suppression).
  - seg_out[7] = latched dp_mask bit.
- Blink: when the latched blink bit = 1 and blink_phase = 1, seg_out = 8'h00. dig_sel remains asserted.
  - blink_phase is re-evaluated every cycle, not only at latch time. The blink therefore follows clk_4hz within 2 cycles.
- Data coherency: changes on bcd_in during DRIVE are not shown until that digit's next BLANK.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset then idle: rst_n low 3 cycles → seg_out=00, dig_sel=6'h3F, scan_idx=0. Release reset with clk_300hz held low → outputs unchanged for 50 cycles.
- Basic scan: bcd_in=24'h123456. Toggle clk_300hz every 4 clk cycles (rising edge every 8).
  - First edge → dig_sel=3F one cycle, then dig_sel=3E with seg_out=7D (digit0=6).
  - Next edges show 6D (5), 66 (4), 4F (3), 5B (2), 06 (1).
  - Then the index wraps and digit0 shows 7D again.
- Latency and blanking: check that exactly one all-ones dig_sel cycle separates every digit, and that new digit data appears 2 cycles after the sampled rising edge.
- Blink: blink_mask=6'b000011, clk_4hz=1.
  - Digits 0 and 1 → seg_out=00, dig_sel still asserted.
  - Drop clk_4hz to 0 → within 2 cycles seg_out=7D on digit 0.
  - Other digits are unaffected throughout.
- Blank codes, dp and coherency:
  - bcd_in=24'hFF0930 with dp_mask=6'b000100 → digit2 shows 0xEF; digits 4 and 5 show 00.
  - Change bcd_in mid-DRIVE → displayed value holds until that digit's next BLANK.
- Reset mid-scan: assert rst_n while scan_idx=3 in DRIVE → outputs go to reset values without a clock edge. After release, the first scan_edge drives digit 0.
